// File: rtl/dot_seq_pkg.sv
// Shared types and defaults for the dot-product sequencer.
// Optional build macro: DOT_SEQ_PERF_EN adds cycle/job performance counters.
package dot_seq_pkg;

  localparam int unsigned DefAwidth   = 9;
  localparam int unsigned DefDwidth   = 40;
  localparam int unsigned DefCuLat    = 5;
  localparam int unsigned DefRdLat    = 1;
  localparam int unsigned CuOutWidth  = 32;
  // Zero padding placed above the compute-unit result in a written word.
  localparam int unsigned DefPadWidth = DefDwidth - CuOutWidth;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StExt   = 3'd1,
    StIssue = 3'd2,
    StDrain = 3'd3,
    StFin   = 3'd4
  } seq_state_e;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/dot_seq_valid_pipe.sv
// Valid shift register tracking issued reads through BRAM and compute unit.
// tap marks the entry leaving the last stage this cycle; empty is high when,
// after the coming edge, no entry remains behind the tap stage.
module dot_seq_valid_pipe #(
  parameter int unsigned Depth = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic tap,
  output logic empty
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] valid_d;
  logic [Depth-1:0] behind;

  // Shift toward the tap, inserting the new issue at stage 0.
  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = in_valid;
    behind     = valid_d << 1;
  end

  // Stage registers, cleared on reset so an aborted job leaves nothing in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign tap   = valid_q[Depth-1];
  assign empty = (behind == '0);

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams num_vec words from BRAM port B through an external compute unit and
// writes each 32-bit result back via port A, with an idle-time external grant.
// Optional build macro: DOT_SEQ_PERF_EN adds cycle_cnt/job_cnt outputs.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter int unsigned AWIDTH = DefAwidth,
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned CU_LAT = DefCuLat,
  parameter int unsigned RD_LAT = DefRdLat
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] num_vec,
  input  logic [AWIDTH-1:0] in_base,
  input  logic [AWIDTH-1:0] out_base,
  output logic              busy,
  output logic              done,
  input  logic              ext_req,
  output logic              ext_gnt,
  output logic [AWIDTH-1:0] addr_a,
  output logic              wren_a,
  output logic [DWIDTH-1:0] wdata_a,
  output logic [AWIDTH-1:0] addr_b,
  output logic              wren_b,
  input  logic [DWIDTH-1:0] rdata_b,
  output logic [DWIDTH-1:0] cu_inp,
  input  logic [31:0]       cu_out
`ifdef DOT_SEQ_PERF_EN
  ,
  output logic [15:0]       cycle_cnt,
  output logic [15:0]       job_cnt
`endif
);

  localparam int unsigned Depth    = RD_LAT + CU_LAT;
  localparam int unsigned PadWidth = DWIDTH - CuOutWidth;

  seq_state_e        state_q;
  logic [AWIDTH-1:0] nv_q;
  logic [AWIDTH-1:0] in_base_q;
  logic [AWIDTH-1:0] out_base_q;
  logic [AWIDTH-1:0] iss_cnt_q;
  logic [AWIDTH-1:0] res_cnt_q;
  logic              issue_valid;
  logic              pipe_tap;
  logic              pipe_empty;

  assign issue_valid = (state_q == StIssue);
  assign cu_inp      = rdata_b;
  assign wren_b      = 1'b0;

  dot_seq_valid_pipe #(
    .Depth(Depth)
  ) u_valid_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_valid(issue_valid),
    .tap     (pipe_tap),
    .empty   (pipe_empty)
  );

  // Job FSM with registered outputs and the result write-back port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      nv_q       <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      iss_cnt_q  <= '0;
      res_cnt_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ext_gnt    <= 1'b0;
      wren_a     <= 1'b0;
      addr_a     <= '0;
      wdata_a    <= '0;
      addr_b     <= '0;
    end else begin
      done   <= 1'b0;
      wren_a <= 1'b0;
      // A tap lines up with the compute-unit output for that issue.
      if (pipe_tap) begin
        wren_a    <= 1'b1;
        addr_a    <= out_base_q + res_cnt_q;
        wdata_a   <= {{PadWidth{1'b0}}, cu_out};
        res_cnt_q <= res_cnt_q + AWIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nv_q       <= num_vec;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            iss_cnt_q  <= '0;
            res_cnt_q  <= '0;
            addr_b     <= in_base;
            busy       <= 1'b1;
            state_q    <= (num_vec == '0) ? StFin : StIssue;
          end else if (ext_req) begin
            ext_gnt <= 1'b1;
            state_q <= StExt;
          end
        end
        StExt: begin
          if (!ext_req) begin
            ext_gnt <= 1'b0;
            state_q <= StIdle;
          end
        end
        StIssue: begin
          iss_cnt_q <= iss_cnt_q + AWIDTH'(1);
          addr_b    <= in_base_q + iss_cnt_q + AWIDTH'(1);
          if (iss_cnt_q == nv_q - AWIDTH'(1)) begin
            // FIN is the cycle in which the final entry leaves the tap.
            state_q <= pipe_empty ? StFin : StDrain;
          end
        end
        StDrain: begin
          if (pipe_empty) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DOT_SEQ_PERF_EN
  logic [15:0] run_q;

  // Job cycle counter: the accepting cycle counts as 1; the +2 at FIN covers
  // the FIN cycle and the following done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= '0;
      cycle_cnt <= '0;
      job_cnt   <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        run_q <= 16'd1;
      end else if (busy) begin
        run_q <= sat_add16(run_q, 16'd1);
      end
      if (state_q == StFin) begin
        cycle_cnt <= sat_add16(run_q, 16'd2);
        job_cnt   <= job_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed and random jobs against a BRAM/compute-unit environment; expected
// writes and latencies come from a job-level reference model.
module tb_dot_product_sequencer;

  localparam int AW    = 9;
  localparam int DW    = 40;
  localparam int CL    = 5;
  localparam int RL    = 1;
  localparam int DEPTH = RL + CL;
  localparam int NWORD = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_vec;
  logic [AW-1:0] in_base;
  logic [AW-1:0] out_base;
  logic          busy;
  logic          done;
  logic          ext_req;
  logic          ext_gnt;
  logic [AW-1:0] addr_a;
  logic          wren_a;
  logic [DW-1:0] wdata_a;
  logic [AW-1:0] addr_b;
  logic          wren_b;
  logic [DW-1:0] rdata_b;
  logic [DW-1:0] cu_inp;
  logic [31:0]   cu_out;
`ifdef DOT_SEQ_PERF_EN
  logic [15:0]   cycle_cnt;
  logic [15:0]   job_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(
    .AWIDTH(AW),
    .DWIDTH(DW),
    .CU_LAT(CL),
    .RD_LAT(RL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_vec  (num_vec),
    .in_base  (in_base),
    .out_base (out_base),
    .busy     (busy),
    .done     (done),
    .ext_req  (ext_req),
    .ext_gnt  (ext_gnt),
    .addr_a   (addr_a),
    .wren_a   (wren_a),
    .wdata_a  (wdata_a),
    .addr_b   (addr_b),
    .wren_b   (wren_b),
    .rdata_b  (rdata_b),
    .cu_inp   (cu_inp),
    .cu_out   (cu_out)
`ifdef DOT_SEQ_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .job_cnt  (job_cnt)
`endif
  );

  // Compute-unit function: five byte lanes, each a nibble pair (a,b); sum of a*b.
  function automatic logic [31:0] dot_fn(input logic [DW-1:0] w);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < DW / 8; i++) begin
      s += 32'(w[8*i+4 +: 4]) * 32'(w[8*i +: 4]);
    end
    return s;
  endfunction

  // Environment: BRAM with RL-cycle read, compute unit with CL-cycle latency.
  logic [DW-1:0] mem [NWORD];
  logic [DW-1:0] rd_pipe [RL];
  logic [31:0]   cu_pipe [CL];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[addr_b];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    cu_pipe[0] <= dot_fn(cu_inp);
    for (int i = 1; i < CL; i++) cu_pipe[i] <= cu_pipe[i-1];
  end
  assign rdata_b = rd_pipe[RL-1];
  assign cu_out  = cu_pipe[CL-1];

  // Write monitor: logs every port-A write; only this process touches the logs.
  logic [AW-1:0] wa_log [$];
  logic [DW-1:0] wd_log [$];
  logic          wren_b_seen = 1'b0;

  always @(negedge clk) begin
    if (wren_a) begin
      wa_log.push_back(addr_a);
      wd_log.push_back(wdata_a);
    end
    if (wren_b) wren_b_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: start pulse, per-cycle addr_b check, latency check, write scoreboard.
  task automatic run_job(input int nv, input int ib, input int ob, input bit with_ext,
                         input bit poke);
    int          base;
    int          k;
    int          limit;
    int          cnt;
    bit          gnt_seen;
    logic [DW-1:0] exp_d;
    base     = wa_log.size();
    limit    = nv + DEPTH + 20;
    gnt_seen = 1'b0;
    @(negedge clk);
    num_vec  = AW'(nv);
    in_base  = AW'(ib);
    out_base = AW'(ob);
    start    = 1'b1;
    if (with_ext) ext_req = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk("busy_first", busy, 1);
    while (done !== 1'b1 && k <= limit) begin
      if (k - 1 < nv) chk("addr_b", addr_b, (ib + k - 1) % NWORD);
      if (with_ext && ext_gnt) gnt_seen = 1'b1;
      if (poke) start = (k == 2);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_latency", k, (nv == 0) ? 2 : nv - 1 + DEPTH + 2);
    chk("busy_at_done", busy, 0);
    if (with_ext) chk("ext_gnt_during_job", gnt_seen, 0);
    @(negedge clk);
    #1;
    chk("done_one_pulse", done, 0);
    cnt = wa_log.size() - base;
    chk("write_count", cnt, nv);
    for (int j = 0; j < nv && j < cnt; j++) begin
      exp_d       = '0;
      exp_d[31:0] = dot_fn(mem[(ib + j) % NWORD]);
      chk("write_addr", wa_log[base+j], (ob + j) % NWORD);
      chk("write_data", wd_log[base+j], exp_d);
    end
  endtask

  initial begin
    logic [63:0] r;
    int          b;
    bit          done_seen;
    reset    = 1'b1;
    start    = 1'b0;
    ext_req  = 1'b0;
    num_vec  = '0;
    in_base  = '0;
    out_base = '0;
    for (int i = 0; i < NWORD; i++) begin
      r      = {$urandom(), $urandom()};
      mem[i] = r[DW-1:0];
    end
    for (int i = 0; i < 4; i++) mem[i] = 40'h12_1212_1212;

    // Reset state.
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_wren_a", wren_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_wdata_a", wdata_a, 0);
    chk("rst_wren_b", wren_b, 0);
    reset = 1'b1;
    @(negedge clk);

    // Four (1,2)-pair words -> 100..103 each receive 10.
    b = wa_log.size();
    run_job(4, 0, 100, 1'b0, 1'b0);
    for (int j = 0; j < 4 && b + j < wd_log.size(); j++) begin
      chk("pairs_data", wd_log[b+j], 40'd10);
      chk("pairs_addr", wa_log[b+j], 100 + j);
    end

    // Empty job, single-word job, and address wrap past the top.
    run_job(0, 5, 7, 1'b0, 1'b0);
    run_job(1, 33, 44, 1'b0, 1'b0);
    run_job(4, 510, 20, 1'b0, 1'b0);

    // External owner holds port A; start is ignored until it lets go.
    @(negedge clk);
    ext_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("ext_gnt_on", ext_gnt, 1);
    b        = wa_log.size();
    num_vec  = AW'(3);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ext_busy", busy, 0);
    chk("ext_gnt_hold", ext_gnt, 1);
    chk("ext_no_write", wa_log.size() - b, 0);
    ext_req = 1'b0;
    @(negedge clk);
    chk("ext_gnt_off", ext_gnt, 0);
    run_job(3, 40, 200, 1'b0, 1'b0);

    // start and ext_req together: the job wins, grant follows afterwards.
    run_job(5, 100, 300, 1'b1, 1'b0);
    chk("ext_gnt_after_job", ext_gnt, 1);
    ext_req = 1'b0;
    repeat (2) @(negedge clk);

    // start while busy is dropped, not queued.
    run_job(3, 60, 70, 1'b0, 1'b1);
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) done_seen = 1'b1;
    end
    chk("no_queued_start", done_seen, 0);

    // Reset in the middle of draining a 6-word job.
    @(negedge clk);
    num_vec  = AW'(6);
    in_base  = AW'(300);
    out_base = AW'(400);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wren_a", wren_a, 0);
    chk("abort_addr_a", addr_a, 0);
    chk("abort_addr_b", addr_b, 0);
    chk("abort_wdata_a", wdata_a, 0);
    chk("abort_ext_gnt", ext_gnt, 0);
    b = wa_log.size();
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_write", wa_log.size() - b, 0);
    run_job(6, 300, 400, 1'b0, 1'b0);

    // Random jobs, then the largest job the counters allow.
    for (int t = 0; t < 4; t++) begin
      run_job(int'($urandom_range(1, 24)), int'($urandom_range(0, NWORD - 1)),
              int'($urandom_range(0, NWORD - 1)), 1'b0, 1'b0);
    end
    run_job(NWORD - 1, 7, 9, 1'b0, 1'b0);

    chk("wren_b_never", wren_b_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 9, BRAM address width; DWIDTH, default 40, BRAM data width; CU_LAT, default 5, compute-unit input-to-output cycles; RD_LAT, default 1, BRAM read latency.
REQ-002 Ports SHALL be, clock and reset first:
 - clk, in, 1: single clock; all logic on its rising edge.
 - reset, in, 1: asynchronous, active-low.
 - start, in, 1: job request, sampled in IDLE only.
 - num_vec, in, AWIDTH: number of input words in the job.
 - in_base, in, AWIDTH: first input address.
 - out_base, in, AWIDTH: first result address.
 - busy, out, 1: a job is in progress.
 - done, out, 1: one-cycle job-complete pulse.
 - ext_req, in, 1: external port-A access request.
 - ext_gnt, out, 1: external owns port A.
 - addr_a, out, AWIDTH; wren_a, out, 1; wdata_a, out, DWIDTH: port-A result-write interface.
 - addr_b, out, AWIDTH; wren_b, out, 1: port-B read interface.
 - rdata_b, in, DWIDTH: port-B read data.
 - cu_inp, out, DWIDTH: compute-unit operands.
 - cu_out, in, 32: compute-unit result.

Function
REQ-003 The FSM SHALL have states IDLE, EXT, ISSUE, DRAIN, FIN; the encoding is held in the package.
REQ-004 In IDLE with start=1, the block SHALL latch num_vec, in_base and out_base and enter ISSUE. If num_vec=0, it SHALL enter FIN instead.
REQ-005 In IDLE with start=0 and ext_req=1, the block SHALL enter EXT. start SHALL win when start and ext_req are asserted in the same cycle.
REQ-006 In EXT, ext_gnt SHALL be 1, and the block SHALL return to IDLE the cycle after ext_req=0. start SHALL be ignored while in EXT.
REQ-007 In ISSUE, addr_b SHALL be in_base+k for k=0..num_vec-1, one address per cycle. After the last issue the block SHALL enter DRAIN.
REQ-008 Addresses SHALL wrap modulo 2^AWIDTH.
REQ-009 cu_inp SHALL equal rdata_b.
REQ-010 A valid shift register of depth RD_LAT+CU_LAT SHALL track every issued address.
REQ-011 When a tap exits the shift register, the block SHALL assert wren_a=1 with addr_a=out_base+j and wdata_a={(DWIDTH-32) zeros, cu_out}, where j is the result index.
REQ-012 The block SHALL leave DRAIN for FIN when the shift register is empty.
REQ-013 FIN SHALL last one cycle, assert done=1, and return to IDLE.
REQ-014 busy SHALL be 1 in ISSUE, DRAIN and FIN.
REQ-015 wren_b SHALL be 0 at all times.
REQ-016 wren_a SHALL be 0 outside result writes.
REQ-017 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-018 num_vec=1 SHALL complete with exactly one write, with done asserted RD_LAT+CU_LAT+2 cycles after start.
REQ-019 The result counter SHALL be AWIDTH bits wide. num_vec=2^AWIDTH-1 SHALL complete without overflow.

Reset
REQ-020 On reset low, the block SHALL asynchronously clear the following to 0: state (IDLE), counters, the shift register, busy, done, ext_gnt, wren_a, addr_a, addr_b and wdata_a.
REQ-021 Reset asserted mid-job SHALL abort the job with no further writes and no done pulse. Release SHALL be synchronous to clk.

Configuration
REQ-022 With DOT_SEQ_PERF_EN defined, the block SHALL add two outputs:
 - cycle_cnt, 16 bits: cycles from start acceptance to done, inclusive; saturating at 16'hFFFF; updated at FIN; reset 0.
 - job_cnt, 16 bits: wrapping count of completed jobs.
REQ-023 Without DOT_SEQ_PERF_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package dot_seq_pkg SHALL hold the state typedef, the default AWIDTH/DWIDTH/CU_LAT/RD_LAT constants, and the result-pad width DWIDTH-32.
REQ-025 One sub-module, dot_seq_valid_pipe, SHALL implement the parameterised valid shift register and expose empty and tap outputs.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
 - num_vec=4, in_base=0, out_base=100, each input word holding pairs (1,2) -> addresses 100..103 each written with 10, then one done pulse.
 - num_vec=0 -> done two cycles after start, zero wren_a.
 - in_base=510, num_vec=4 -> addr_b sequence 510, 511, 0, 1.
 - ext_req held while idle, then start pulsed -> ext_gnt=1 and no job starts; after ext_req drops, a new start pulse runs the job.
 - start and ext_req in the same cycle -> job runs and ext_gnt stays 0 until FIN.
 - reset low during DRAIN of a 6-vector job -> all outputs 0 immediately, no done pulse, and the next start runs cleanly.
